// File: rtl/a7seg_pkg.sv
// Shared constants, types and the hex-to-segment table for the 4-digit scan controller.
package a7seg_pkg;

   // Register map
   localparam logic [1:0] ADDR_VALUE = 2'd0;
   localparam logic [1:0] ADDR_RAW   = 2'd1;
   localparam logic [1:0] ADDR_CTRL  = 2'd2;
   localparam logic [1:0] ADDR_RSVD  = 2'd3;

   // VALUE field offsets; bits [31:28] have no storage and always read 0
   localparam int unsigned VAL_NIB_LSB   = 0;
   localparam int unsigned VAL_DP_LSB    = 16;
   localparam int unsigned VAL_BLANK_LSB = 20;
   localparam int unsigned VAL_BLINK_LSB = 24;
   localparam int unsigned VAL_IMPL_BITS = 28;

   // CTRL bit positions
   localparam int unsigned CTRL_MODE_BIT = 0;
   localparam int unsigned CTRL_EN_BIT   = 1;
   localparam int unsigned CTRL_PEND_BIT = 2;

   // Segment byte that turns every segment (and dp) off; outputs are active-low
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Display configuration held both as CPU-visible shadow and as the active copy
   typedef struct packed {
      logic [31:0] value;
      logic [31:0] raw;
      logic        mode;    // 0: hex nibbles, 1: raw segment bytes
      logic        enable;
   } disp_cfg_t;

   // Reset constants
   localparam logic [31:0] VALUE_RST  = 32'h0000_0000;
   localparam logic [31:0] RAW_RST    = 32'hFFFF_FFFF;
   localparam logic        MODE_RST   = 1'b0;
   localparam logic        ENABLE_RST = 1'b1;
   localparam logic [31:0] RDATA_RST  = 32'h0000_0000;
   localparam logic [31:0] DATA_RST   = 32'hFFFF_FFFF;

   localparam disp_cfg_t CFG_RST = '{
      value:  VALUE_RST,
      raw:    RAW_RST,
      mode:   MODE_RST,
      enable: ENABLE_RST
   };

   // Hex-to-segment table, dp off; entry n lives in bits [8n+7:8n]
   localparam logic [127:0] HEX_SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      return HEX_SEG_TABLE[{nib, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/a7seg_hex_enc.sv
// Combinational nibble-to-segment encoder with decimal point; one instance per digit.
module a7seg_hex_enc
   import a7seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   // Table lookup, then pull bit7 low (active) when the decimal point is lit
   always_comb begin
      seg_o    = hex_to_seg(nibble_i);
      seg_o[7] = seg_o[7] & ~dp_i;
   end

endmodule

// File: rtl/a7seg_scan_ctrl.sv
// Bus-facing 4-digit 7-segment scan controller: display registers, digit scan, blink phase
// and segment-byte encoding. Byte data[31:24] drives digit 0 (scan=0), data[7:0] digit 3.
// Optional feature: define A7SEG_FRAME_SYNC_EN to defer register commits to frame boundaries.
module a7seg_scan_ctrl
   import a7seg_pkg::*;
#(
   parameter int unsigned SCAN_PERIOD  = 50000,
   parameter int unsigned FLASH_PERIOD = 250
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        we,
   input  logic        re,
   input  logic [1:0]  addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [1:0]  scan,
   output logic        flash,
   output logic [31:0] data
);

   localparam int unsigned PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int unsigned FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [1:0]    scan_q, scan_d;
   logic          flash_q, flash_d;
   logic          tick, flash_wrap, frame;

   disp_cfg_t     shad_q, shad_d;
   disp_cfg_t     act;
   logic          pending;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   data_q, data_d;
   logic [3:0][7:0] seg_byte;

   // ---------------------------------------------------------------------------------------
   // Timebase
   // ---------------------------------------------------------------------------------------

   assign tick       = (presc_q == PW'(SCAN_PERIOD - 1));
   assign flash_wrap = tick && (fcnt_q == FW'(FLASH_PERIOD - 1));
   assign frame      = tick && (scan_q == 2'd3);

   // Prescaler, digit index and flash phase next-state
   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      scan_d  = tick ? scan_q + 2'd1 : scan_q;
      fcnt_d  = fcnt_q;
      flash_d = flash_q;
      if (tick) begin
         fcnt_d = flash_wrap ? '0 : fcnt_q + FW'(1);
      end
      if (flash_wrap) begin
         flash_d = ~flash_q;
      end
   end

   // Timebase state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc_q <= '0;
         fcnt_q  <= '0;
         scan_q  <= 2'd0;
         flash_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         fcnt_q  <= fcnt_d;
         scan_q  <= scan_d;
         flash_q <= flash_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Shadow registers (CPU side)
   // ---------------------------------------------------------------------------------------

   // Byte-enabled writes; unimplemented bits are forced back to zero
   always_comb begin
      shad_d = shad_q;
      if (we) begin
         case (addr)
            ADDR_VALUE: begin
               for (int i = 0; i < 4; i++) begin
                  if (be[i]) shad_d.value[8*i +: 8] = wdata[8*i +: 8];
               end
               shad_d.value[31:VAL_IMPL_BITS] = '0;
            end
            ADDR_RAW: begin
               for (int i = 0; i < 4; i++) begin
                  if (be[i]) shad_d.raw[8*i +: 8] = wdata[8*i +: 8];
               end
            end
            ADDR_CTRL: begin
               if (be[0]) begin
                  shad_d.mode   = wdata[CTRL_MODE_BIT];
                  shad_d.enable = wdata[CTRL_EN_BIT];
               end
            end
            default: ;
         endcase
      end
   end

   // Shadow register state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shad_q <= CFG_RST;
      end else begin
         shad_q <= shad_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Active copy used by the display path
   // ---------------------------------------------------------------------------------------

`ifdef A7SEG_FRAME_SYNC_EN
   disp_cfg_t act_q;
   logic      pending_q, pending_d;

   // A write on the boundary edge wins over the clear, so it commits one frame later
   always_comb begin
      pending_d = pending_q;
      if (we) begin
         pending_d = 1'b1;
      end else if (frame) begin
         pending_d = 1'b0;
      end
   end

   // Commit the pre-edge shadow at each frame boundary
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         act_q     <= CFG_RST;
         pending_q <= 1'b0;
      end else begin
         if (frame) act_q <= shad_q;
         pending_q <= pending_d;
      end
   end

   assign act     = act_q;
   assign pending = pending_q;
`else
   // Immediate commit: the display path sees the shadow one cycle after the write
   assign act     = shad_q;
   assign pending = 1'b0;
`endif

   // ---------------------------------------------------------------------------------------
   // Register read port
   // ---------------------------------------------------------------------------------------

   // Reads return the pre-write shadow; rdata holds when no read is strobed
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         case (addr)
            ADDR_VALUE: rdata_d = shad_q.value;
            ADDR_RAW:   rdata_d = shad_q.raw;
            ADDR_CTRL:  rdata_d = {29'd0, pending, shad_q.enable, shad_q.mode};
            default:    rdata_d = '0;
         endcase
      end
   end

   // Read data register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_q <= RDATA_RST;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Segment output path
   // ---------------------------------------------------------------------------------------

   for (genvar g = 0; g < 4; g++) begin : g_digit
      a7seg_hex_enc u_enc (
         .nibble_i (act.value[VAL_NIB_LSB + 4*g +: 4]),
         .dp_i     (act.value[VAL_DP_LSB + g]),
         .seg_o    (seg_byte[g])
      );
   end

   // Per-digit select: disable, blank and blink-off all darken the digit, else raw or hex
   always_comb begin
      data_d = DATA_RST;
      for (int i = 0; i < 4; i++) begin
         if (!act.enable || act.value[VAL_BLANK_LSB + i] ||
             (act.value[VAL_BLINK_LSB + i] && flash_q)) begin
            data_d[8*(3-i) +: 8] = SEG_BLANK;
         end else if (act.mode) begin
            data_d[8*(3-i) +: 8] = act.raw[8*i +: 8];
         end else begin
            data_d[8*(3-i) +: 8] = seg_byte[i];
         end
      end
   end

   // Segment data register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= DATA_RST;
      end else begin
         data_q <= data_d;
      end
   end

   assign rdata = rdata_q;
   assign scan  = scan_q;
   assign flash = flash_q;
   assign data  = data_q;

endmodule
